blit_rect_sequencer: RTL and testbench

- Command front-end for the blitter rectangle walker.
- Accepts rectangle-copy/fill commands from the CPU-side register bus into a small FIFO.
- Loads each command's geometry into the walker, holds `start` for the walk and waits for the walker's `done`.
- Drains the pixel pipeline, then retires the command and reports status/interrupt.

---
 rtl/blit_rect_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_blit_rect_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blit_rect_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : blit_rect_sequencer
// Brief    : Command front-end for the blitter rectangle walker. Queues
//            rectangle commands, hands each one to the walker, waits for the
//            walk and the pipeline drain, then retires it and raises an
//            optional one-cycle interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module blit_rect_sequencer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_reversed,
    input  logic [15:0] cmd_width,
    input  logic [15:0] cmd_height,
    input  logic [15:0] cmd_x1,
    input  logic [15:0] cmd_y1,
    input  logic [15:0] cmd_x2,
    input  logic [15:0] cmd_y2,
    input  logic        abort,
    input  logic        irq_enable,
    output logic        rect_start,
    output logic        rect_reversed,
    output logic [15:0] rect_width,
    output logic [15:0] rect_height,
    output logic [15:0] rect_x1,
    output logic [15:0] rect_y1,
    output logic [15:0] rect_x2,
    output logic [15:0] rect_y2,
    input  logic        rect_done,
    output logic        busy,
    output logic [4:0]  fifo_count,
    output logic [15:0] cmd_done_count,
    output logic        irq
);

    localparam int                   c_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                   c_DRAIN_W    = $clog2(DRAIN_CYCLES + 2);
    localparam logic [4:0]           c_DEPTH      = 5'(FIFO_DEPTH);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LOAD = c_DRAIN_W'(DRAIN_CYCLES);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    typedef struct packed {
        logic        reversed;
        logic [15:0] width;
        logic [15:0] height;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
    } cmd_t;

    cmd_t                 r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [4:0]           r_count;
    logic [1:0]           r_state;
    logic [c_DRAIN_W-1:0] r_drain;
    cmd_t                 r_rect;
    logic [15:0]          r_done_count;
    logic                 r_irq;

    logic [1:0]           w_state_nxt;
    logic [c_DRAIN_W-1:0] w_drain_nxt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_retire;
    cmd_t                 w_head;
    cmd_t                 w_cmd_in;

    // Readiness comes from the registered count only, so a full FIFO never
    // accepts even when the head is being popped in the same cycle.
    assign cmd_ready = (r_count != c_DEPTH);
    assign w_push    = cmd_valid && cmd_ready && !abort;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_cmd_in  = {cmd_reversed, cmd_width, cmd_height, cmd_x1, cmd_y1, cmd_x2, cmd_y2};

    assign rect_start     = (r_state == c_RUN);
    assign rect_reversed  = r_rect.reversed;
    assign rect_width     = r_rect.width;
    assign rect_height    = r_rect.height;
    assign rect_x1        = r_rect.x1;
    assign rect_y1        = r_rect.y1;
    assign rect_x2        = r_rect.x2;
    assign rect_y2        = r_rect.y2;
    assign busy           = (r_state != c_IDLE) || (r_count != 5'd0);
    assign fifo_count     = r_count;
    assign cmd_done_count = r_done_count;
    assign irq            = r_irq;

    // Command storage: written on every accepted push, no reset needed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_cmd_in;
        end
    end

    // Next-state, pop and retire decisions; nothing moves while stalled.
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain;
        w_pop       = 1'b0;
        w_retire    = 1'b0;
        if (!stall) begin
            case (r_state)
                c_IDLE: begin
                    if (r_count != 5'd0) begin
                        w_state_nxt = c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (r_count == 5'd0) begin
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_pop = 1'b1;
                        if ((w_head.width == 16'd0) || (w_head.height == 16'd0)) begin
                            // Empty rectangle: nothing to walk, retire at once.
                            w_retire    = 1'b1;
                            w_state_nxt = c_IDLE;
                        end else begin
                            w_state_nxt = c_RUN;
                        end
                    end
                end
                c_RUN: begin
                    if (rect_done) begin
                        w_drain_nxt = c_DRAIN_LOAD;
                        w_state_nxt = c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (r_drain == '0) begin
                        w_retire    = 1'b1;
                        w_state_nxt = (r_count != 5'd0) ? c_LOAD : c_IDLE;
                    end else begin
                        w_drain_nxt = r_drain - c_DRAIN_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                end
            endcase
        end
    end

    // Sequencer state, FIFO bookkeeping, walker geometry and retire status.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_drain      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= 5'd0;
            r_rect       <= '0;
            r_done_count <= 16'd0;
            r_irq        <= 1'b0;
        end else if (abort) begin
            // Flush everything queued and cancel the walk without retiring.
            r_state  <= c_IDLE;
            r_drain  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
            r_irq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_drain <= w_drain_nxt;
            r_irq   <= w_retire && irq_enable;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_rect   <= w_head;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_retire) begin
                r_done_count <= r_done_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blit_rect_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_blit_rect_sequencer
// Brief    : Self-checking bench for blit_rect_sequencer: directed command
//            sequences, a simple walker, and a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blit_rect_sequencer;

    localparam int c_DEPTH = 4;
    localparam int c_DRAIN = 3;
    localparam int c_WALK  = 8;

    typedef struct packed {
        logic        rev;
        logic [15:0] w;
        logic [15:0] h;
        logic [15:0] x1;
        logic [15:0] y1;
        logic [15:0] x2;
        logic [15:0] y2;
    } cmd_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_reversed;
    logic [15:0] cmd_width;
    logic [15:0] cmd_height;
    logic [15:0] cmd_x1;
    logic [15:0] cmd_y1;
    logic [15:0] cmd_x2;
    logic [15:0] cmd_y2;
    logic        abort;
    logic        irq_enable;
    logic        rect_start;
    logic        rect_reversed;
    logic [15:0] rect_width;
    logic [15:0] rect_height;
    logic [15:0] rect_x1;
    logic [15:0] rect_y1;
    logic [15:0] rect_x2;
    logic [15:0] rect_y2;
    logic        rect_done = 1'b0;
    logic        busy;
    logic [4:0]  fifo_count;
    logic [15:0] cmd_done_count;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Scoreboard state.
    cmd_t        mq[$];
    cmd_t        act;
    int          drain_left = 0;
    logic [15:0] m_done = 16'd0;
    logic        p_start = 1'b0;

    blit_rect_sequencer #(.FIFO_DEPTH(c_DEPTH), .DRAIN_CYCLES(c_DRAIN)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_reversed   (cmd_reversed),
        .cmd_width      (cmd_width),
        .cmd_height     (cmd_height),
        .cmd_x1         (cmd_x1),
        .cmd_y1         (cmd_y1),
        .cmd_x2         (cmd_x2),
        .cmd_y2         (cmd_y2),
        .abort          (abort),
        .irq_enable     (irq_enable),
        .rect_start     (rect_start),
        .rect_reversed  (rect_reversed),
        .rect_width     (rect_width),
        .rect_height    (rect_height),
        .rect_x1        (rect_x1),
        .rect_y1        (rect_y1),
        .rect_x2        (rect_x2),
        .rect_y2        (rect_y2),
        .rect_done      (rect_done),
        .busy           (busy),
        .fifo_count     (fifo_count),
        .cmd_done_count (cmd_done_count),
        .irq            (irq)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, a, e);
        end
    endtask

    // Walker: completes a walk after start has been seen for c_WALK cycles.
    int run_cnt = 0;
    always @(negedge clock) begin
        if (rect_start === 1'b1) run_cnt++;
        else                     run_cnt = 0;
        rect_done = (rect_start === 1'b1) && (run_cnt >= c_WALK);
    end

    // Scoreboard: commands leave the queue in order, each walk shows the
    // geometry it was queued with, retirement follows walk completion by
    // DRAIN+1 unstalled cycles, and skipped commands retire without a walk.
    always @(posedge clock) begin
        logic s_reset, s_abort, s_stall, s_valid, s_done, s_irqen, s_ready;
        logic done_smp, exp_ret, inc, rose;
        cmd_t s_cmd;
        s_reset  = reset;
        s_abort  = abort;
        s_stall  = stall;
        s_valid  = cmd_valid;
        s_done   = rect_done;
        s_irqen  = irq_enable;
        s_cmd    = {cmd_reversed, cmd_width, cmd_height, cmd_x1, cmd_y1, cmd_x2, cmd_y2};
        s_ready  = (mq.size() != c_DEPTH);
        done_smp = p_start && s_done && !s_stall;
        #1;
        if (s_reset) begin
            mq.delete();
            drain_left = 0;
            m_done     = 16'd0;
            chk("reset_outputs", 128'({rect_start, irq, busy, cmd_ready, fifo_count, cmd_done_count}),
                128'({1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 16'd0}));
            chk("reset_geometry", 128'({rect_reversed, rect_width, rect_height, rect_x1, rect_y1, rect_x2, rect_y2}),
                128'(0));
        end else if (s_abort) begin
            mq.delete();
            drain_left = 0;
            chk("abort_outputs", 128'({rect_start, irq, busy, fifo_count, cmd_done_count}),
                128'({1'b0, 1'b0, 1'b0, 5'd0, m_done}));
        end else begin
            if (s_valid && s_ready) mq.push_back(s_cmd);
            exp_ret = 1'b0;
            if (drain_left > 0 && !s_stall) begin
                drain_left--;
                if (drain_left == 0) exp_ret = 1'b1;
            end
            inc  = (cmd_done_count != m_done);
            rose = rect_start && !p_start;
            if (exp_ret) begin
                chk("retire_on_time", 128'(inc), 128'(1'b1));
            end else if (inc) begin
                if (mq.size() > 0 && (mq[0].w == 16'd0 || mq[0].h == 16'd0)) void'(mq.pop_front());
                else chk("unexpected_retire", 128'(inc), 128'(1'b0));
            end
            if (exp_ret || inc) begin
                m_done = m_done + 16'd1;
                chk("done_count", 128'(cmd_done_count), 128'(m_done));
                chk("irq_pulse", 128'(irq), 128'(s_irqen));
            end else begin
                chk("irq_quiet", 128'(irq), 128'(1'b0));
            end
            if (done_smp) begin
                drain_left = c_DRAIN + 1;
                chk("start_drop", 128'(rect_start), 128'(1'b0));
            end else if (p_start) begin
                chk("start_hold", 128'(rect_start), 128'(1'b1));
            end
            if (rose) begin
                if (mq.size() > 0) begin
                    act = mq.pop_front();
                    chk("start_nonzero", 128'(act.w != 16'd0 && act.h != 16'd0), 128'(1'b1));
                end else begin
                    chk("start_with_queue", 128'(mq.size()), 128'(1));
                end
            end
            if (rect_start) begin
                chk("geometry", 128'({rect_reversed, rect_width, rect_height, rect_x1, rect_y1, rect_x2, rect_y2}),
                    128'(act));
            end
            chk("fifo_count", 128'(fifo_count), 128'(mq.size()));
            chk("cmd_ready", 128'(cmd_ready), 128'(mq.size() != c_DEPTH));
            chk("busy", 128'(busy), 128'((mq.size() != 0) || rect_start || (drain_left > 0)));
        end
        p_start = rect_start;
    end

    task automatic push(input logic rev, input logic [15:0] w, input logic [15:0] h,
                        input logic [15:0] x1, input logic [15:0] y1,
                        input logic [15:0] x2, input logic [15:0] y2);
        cmd_valid    = 1'b1;
        cmd_reversed = rev;
        cmd_width    = w;
        cmd_height   = h;
        cmd_x1       = x1;
        cmd_y1       = y1;
        cmd_x2       = x2;
        cmd_y2       = y2;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        for (int i = 0; i < 40 && rect_start !== 1'b1; i++) @(negedge clock);
        chk(nm, 128'(rect_start), 128'(1'b1));
    endtask

    task automatic wait_end(input string nm);
        for (int i = 0; i < 40 && rect_start === 1'b1; i++) @(negedge clock);
        chk(nm, 128'(rect_start), 128'(1'b0));
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clock);
        chk(nm, 128'(busy), 128'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        reset = 1'b1; stall = 1'b0; cmd_valid = 1'b0; abort = 1'b0; irq_enable = 1'b1;
        cmd_reversed = 1'b0; cmd_width = '0; cmd_height = '0;
        cmd_x1 = '0; cmd_y1 = '0; cmd_x2 = '0; cmd_y2 = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Single command: start at push+2 for 8 cycles, irq at done+4.
        push(1'b0, 16'd4, 16'd2, 16'd10, 16'd20, 16'd30, 16'd40);
        chk("t1_queued", 128'({busy, fifo_count, rect_start}), 128'({1'b1, 5'd1, 1'b0}));
        @(negedge clock);
        chk("t1_load", 128'(rect_start), 128'(1'b0));
        @(negedge clock);
        chk("t1_start", 128'({rect_start, rect_width, rect_height, rect_x1, rect_y1, rect_x2, rect_y2}),
            128'({1'b1, 16'd4, 16'd2, 16'd10, 16'd20, 16'd30, 16'd40}));
        hi = 1;
        for (int i = 0; i < 40 && rect_start === 1'b1; i++) begin
            @(negedge clock);
            if (rect_start === 1'b1) hi++;
        end
        chk("t1_walk_len", 128'(hi), 128'(8));
        repeat (3) @(negedge clock);
        chk("t1_no_early_irq", 128'({irq, busy}), 128'({1'b0, 1'b1}));
        @(negedge clock);
        chk("t1_irq", 128'({irq, busy, cmd_done_count}), 128'({1'b1, 1'b0, 16'd1}));
        @(negedge clock);
        chk("t1_irq_clear", 128'(irq), 128'(1'b0));

        // Back-to-back: one running plus four queued fills the FIFO.
        push(1'b0, 16'd8, 16'd1, 16'd1, 16'd2, 16'd3, 16'd4);
        wait_start("t2_first_start");
        push(1'b1, 16'd3, 16'd3, 16'd100, 16'd101, 16'd102, 16'd103);
        push(1'b0, 16'd2, 16'd5, 16'd200, 16'd201, 16'd202, 16'd203);
        push(1'b1, 16'd1, 16'd1, 16'd300, 16'd301, 16'd302, 16'd303);
        push(1'b0, 16'd6, 16'd2, 16'd400, 16'd401, 16'd402, 16'd403);
        chk("t2_full", 128'({fifo_count, cmd_ready}), 128'({5'd4, 1'b0}));
        cmd_valid = 1'b1; cmd_width = 16'd9; cmd_height = 16'd9;
        repeat (2) @(negedge clock);
        cmd_valid = 1'b0;
        chk("t2_still_full", 128'(fifo_count), 128'(5'd4));
        wait_idle("t2_idle");
        chk("t2_done", 128'({cmd_done_count, rect_width, rect_height, rect_x1}),
            128'({16'd6, 16'd6, 16'd2, 16'd400}));

        // Zero-size command: no walk, irq at push+2.
        push(1'b0, 16'd0, 16'd5, 16'd7, 16'd7, 16'd7, 16'd7);
        chk("t3_after_push", 128'(irq), 128'(1'b0));
        @(negedge clock);
        chk("t3_load", 128'({irq, rect_start}), 128'({1'b0, 1'b0}));
        @(negedge clock);
        chk("t3_irq", 128'({irq, rect_start, cmd_done_count, busy}), 128'({1'b1, 1'b0, 16'd7, 1'b0}));

        // Stall five cycles during drain: retire slips by exactly five.
        push(1'b0, 16'd2, 16'd2, 16'd5, 16'd6, 16'd7, 16'd8);
        wait_start("t4_start");
        wait_end("t4_end");
        @(negedge clock);
        stall = 1'b1;
        push(1'b1, 16'd3, 16'd1, 16'd11, 16'd12, 16'd13, 16'd14);
        chk("t4_push_in_stall", 128'(fifo_count), 128'(5'd1));
        repeat (4) @(negedge clock);
        stall = 1'b0;
        chk("t4_frozen", 128'({irq, cmd_done_count}), 128'({1'b0, 16'd7}));
        repeat (2) @(negedge clock);
        chk("t4_not_yet", 128'(irq), 128'(1'b0));
        @(negedge clock);
        chk("t4_irq", 128'({irq, cmd_done_count}), 128'({1'b1, 16'd8}));
        wait_idle("t4_idle");
        chk("t4_done", 128'(cmd_done_count), 128'(16'd9));

        // Abort with three queued and one running; same-cycle push dropped.
        push(1'b0, 16'd4, 16'd4, 16'd1, 16'd1, 16'd1, 16'd1);
        wait_start("t5_start");
        push(1'b0, 16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2);
        push(1'b0, 16'd1, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3);
        push(1'b0, 16'd1, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4);
        chk("t5_queued", 128'(fifo_count), 128'(5'd3));
        abort = 1'b1;
        push(1'b0, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5);
        abort = 1'b0;
        chk("t5_abort", 128'({fifo_count, rect_start, busy, irq, cmd_done_count}),
            128'({5'd0, 1'b0, 1'b0, 1'b0, 16'd9}));
        repeat (6) @(negedge clock);
        chk("t5_quiet", 128'({irq, busy, cmd_done_count}), 128'({1'b0, 1'b0, 16'd9}));
        irq_enable = 1'b0;
        push(1'b1, 16'd1, 16'd1, 16'd9, 16'd8, 16'd7, 16'd6);
        wait_idle("t5_idle");
        chk("t5_after", 128'({cmd_done_count, rect_reversed, rect_x1}), 128'({16'd10, 1'b1, 16'd9}));
        irq_enable = 1'b1;

        // Count wrap: preload 0xFFFF, one more retirement gives 0x0000.
        force dut.r_done_count = 16'hFFFF;
        m_done = 16'hFFFF;
        @(posedge clock);
        #2;
        release dut.r_done_count;
        @(negedge clock);
        chk("t6_preload", 128'(cmd_done_count), 128'(16'hFFFF));
        push(1'b0, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
        repeat (2) @(negedge clock);
        chk("t6_wrap", 128'({irq, cmd_done_count}), 128'({1'b1, 16'h0000}));

        // Reset in the middle of a walk.
        push(1'b1, 16'd9, 16'd9, 16'd1, 16'd1, 16'd1, 16'd1);
        wait_start("t7_start");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("t7_reset", 128'({rect_start, irq, busy, cmd_ready, fifo_count, cmd_done_count, rect_width, rect_x1}),
            128'({1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 16'd0, 16'd0, 16'd0}));
        push(1'b0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
        wait_idle("t7_idle");
        chk("t7_done", 128'(cmd_done_count), 128'(16'd1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
